// File: rtl/mem_burst_sequencer_if.sv
// Memory request bus between a request generator and a memory model.
// The generator owns valid and the payload; the memory owns ready.
interface mem_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ID_WIDTH   = 4
);
    logic                      valid;
    logic                      ready;
    logic                      read_enable;
    logic [DATA_WIDTH/8-1:0]   write_enable;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     data;
    logic [ID_WIDTH-1:0]       id;

    modport out (
        output valid, read_enable, write_enable, addr, data, id,
        input  ready
    );

    modport in (
        input  valid, read_enable, write_enable, addr, data, id,
        output ready
    );
endinterface

// File: rtl/mem_burst_sequencer.sv
// Burst request generator: takes one command and emits one memory request per beat
// on consecutive addresses, then reports completion on a done handshake.
module mem_burst_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int ID_WIDTH    = 4,
    parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    input  logic [1:0]             cmd_mode,
    input  logic [DATA_WIDTH-1:0]  cmd_data,
    input  logic [ID_WIDTH-1:0]    cmd_id,
    mem_intf.out                   mem_out,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [ID_WIDTH-1:0]    done_id,
    output logic [COUNT_WIDTH-1:0] done_beats
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_READ       = 2'b00,
        MODE_WR_CONST   = 2'b01,
        MODE_WR_INCR    = 2'b10,
        MODE_RD_WR_INCR = 2'b11
    } mode_e;

    state_e                  state_q,      state_d;
    logic [COUNT_WIDTH-1:0]  beat_q,       beat_d;
    logic [COUNT_WIDTH-1:0]  count_q,      count_d;
    logic                    incr_q,       incr_d;
    logic                    valid_q,      valid_d;
    logic                    re_q,         re_d;
    logic [STRB_WIDTH-1:0]   we_q,         we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [DATA_WIDTH-1:0]   data_q,       data_d;
    logic [ID_WIDTH-1:0]     id_q,         id_d;
    logic                    done_valid_q, done_valid_d;
    logic [ID_WIDTH-1:0]     done_id_q,    done_id_d;
    logic [COUNT_WIDTH-1:0]  done_beats_q, done_beats_d;

    mode_e cmd_mode_e;
    logic  last_beat;

    assign cmd_mode_e = mode_e'(cmd_mode);
    assign last_beat  = (beat_q + COUNT_WIDTH'(1)) == count_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        beat_d       = beat_q;
        count_d      = count_q;
        incr_d       = incr_q;
        valid_d      = valid_q;
        re_d         = re_q;
        we_d         = we_q;
        addr_d       = addr_q;
        data_d       = data_q;
        id_d         = id_q;
        done_valid_d = done_valid_q;
        done_id_d    = done_id_q;
        done_beats_d = done_beats_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_addr;
                    data_d       = cmd_data;
                    id_d         = cmd_id;
                    count_d      = cmd_count;
                    beat_d       = '0;
                    incr_d       = cmd_mode[1];
                    re_d         = (cmd_mode_e == MODE_READ) || (cmd_mode_e == MODE_RD_WR_INCR);
                    we_d         = (cmd_mode_e == MODE_READ) ? '0 : '1;
                    done_id_d    = cmd_id;
                    done_beats_d = cmd_count;
                    // An empty burst skips straight to completion.
                    if (cmd_count == '0) begin
                        done_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (valid_q && mem_out.ready) begin
                    if (last_beat) begin
                        valid_d      = 1'b0;
                        done_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        beat_d = beat_q + COUNT_WIDTH'(1);
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        id_d   = id_q + ID_WIDTH'(1);
                        if (incr_q) begin
                            data_d = data_q + DATA_WIDTH'(1);
                        end
                    end
                end
            end

            ST_DONE: begin
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            count_q      <= '0;
            incr_q       <= 1'b0;
            valid_q      <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            id_q         <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_beats_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            count_q      <= count_d;
            incr_q       <= incr_d;
            valid_q      <= valid_d;
            re_q         <= re_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            id_q         <= id_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_beats_q <= done_beats_d;
        end
    end

    assign cmd_ready            = (state_q == ST_IDLE);
    assign mem_out.valid        = valid_q;
    assign mem_out.read_enable  = re_q;
    assign mem_out.write_enable = we_q;
    assign mem_out.addr         = addr_q;
    assign mem_out.data         = data_q;
    assign mem_out.id           = id_q;
    assign done_valid           = done_valid_q;
    assign done_id              = done_id_q;
    assign done_beats           = done_beats_q;

endmodule
